// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter in front of a single-port word memory.
// Supports locked ownership, out-of-range detection and a one-cycle response pipeline.
module dm_arbiter #(
    parameter int unsigned AW    = 14,
    parameter logic [31:0] LIMIT = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic          m0_we,
    input  logic [31:0]   m0_addr,
    input  logic [3:0]    m0_be,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_we,
    input  logic [31:0]   m1_addr,
    input  logic [3:0]    m1_be,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,

    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t      state;
    logic        rr;          // index of the master granted last
    logic        rsp_valid;
    logic        rsp_owner;
    logic        rsp_err;
    logic        rsp_we;

    logic        any_gnt;
    logic        sel_lock;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic        in_range;
    logic [31:0] rsp_data;
    logic        unused_addr_lsbs;

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = rr;
                        m1_gnt = ~rr;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
                OWN0:    m0_gnt = m0_req;
                OWN1:    m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    assign any_gnt   = m0_gnt | m1_gnt;
    assign sel_lock  = m1_gnt ? m1_lock  : m0_lock;
    assign sel_we    = m1_gnt ? m1_we    : m0_we;
    assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign sel_be    = m1_gnt ? m1_be    : m0_be;
    assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign in_range  = {2'b00, sel_addr[31:2]} < LIMIT;
    assign unused_addr_lsbs = ^sel_addr[1:0];

    assign mem_en    = any_gnt & in_range;
    assign mem_we    = (mem_en && sel_we) ? sel_be : '0;
    assign mem_addr  = any_gnt ? sel_addr[AW+1:2] : '0;
    assign mem_wdata = any_gnt ? sel_wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_we    <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            rsp_owner <= m1_gnt;
            rsp_err   <= any_gnt & ~in_range;
            rsp_we    <= any_gnt & sel_we;
            if (any_gnt)
                rr <= m1_gnt;
            // While owned, a grant happens exactly when the owner requests,
            // so dropping req or lock both release ownership.
            unique case (state)
                IDLE:    if (any_gnt && sel_lock) state <= m1_gnt ? OWN1 : OWN0;
                OWN0:    if (!m0_req || !m0_lock) state <= IDLE;
                OWN1:    if (!m1_req || !m1_lock) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_data  = (rsp_valid && !rsp_err && !rsp_we) ? mem_rdata : '0;
    assign m0_rvalid = rsp_valid & ~rsp_owner;
    assign m1_rvalid = rsp_valid &  rsp_owner;
    assign m0_rdata  = m0_rvalid ? rsp_data : '0;
    assign m1_rdata  = m1_rvalid ? rsp_data : '0;
    assign m0_err    = m0_rvalid & rsp_err;
    assign m1_err    = m1_rvalid & rsp_err;

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter AW, default 14, SHALL set the memory word-index width; mem_addr carries word address bits [AW+1:2].
REQ-002 Parameter LIMIT, default 32'h0000_3000, SHALL set the word count; byte addresses with addr[31:2] >= LIMIT are out of range.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mN_req  input  1  (N = 0,1) access request; held until granted.
REQ-006 mN_lock  input  1  keep ownership after this grant.
REQ-007 mN_we  input  1  1 = write, 0 = read.
REQ-008 mN_addr  input  32  byte address.
REQ-009 mN_be  input  4  byte enables for writes; ignored for reads.
REQ-010 mN_wdata  input  32  write data.
REQ-011 mN_gnt  output  1  combinational grant, same cycle as the accepted request.
REQ-012 mN_rvalid  output  1  response strobe, one cycle after the grant.
REQ-013 mN_rdata  output  32  read data, valid only with mN_rvalid.
REQ-014 mN_err  output  1  out-of-range flag, valid only with mN_rvalid.
REQ-015 mem_en  output  1  memory access enable.
REQ-016 mem_we  output  4  per-byte write strobes.
REQ-017 mem_addr  output  AW  word index.
REQ-018 mem_wdata  output  32  write data to memory.
REQ-019 mem_rdata  input  32  memory read data, registered in memory, available the cycle after mem_en.

Function
REQ-020 At most one mN_gnt SHALL be high per cycle; a grant SHALL only be given to a requesting master; throughput SHALL be one access per cycle.
REQ-021 FSM states: IDLE, OWN0, OWN1.
REQ-022 IDLE: a single requester SHALL be granted; on simultaneous requests the master not granted last (rr pointer) SHALL win.
REQ-023 rr pointer SHALL update to the granted master on every grant.
REQ-024 A grant with mN_lock=1 SHALL move the FSM to OWNn.
REQ-025 OWNn: only master n SHALL be granted; the other SHALL see gnt=0 even if requesting.
REQ-026 OWNn SHALL return to IDLE at the first cycle where master n is granted with lock=0, or where master n has req=0.
REQ-027 In-range grant: mem_en=1, mem_addr=addr[AW+1:2], mem_wdata=wdata, mem_we=be when we=1, else 4'b0000.
REQ-028 Out-of-range grant: mem_en=0 and mem_we=0; the response SHALL carry err=1 and rdata=0.
REQ-029 With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 The response pipeline SHALL register {valid, owner, err, we}.
REQ-031 The next cycle, owner's rvalid=1; rdata=mem_rdata for an in-range read, else 0; the other master's rvalid=0.
REQ-032 Writes SHALL also get rvalid (acknowledge), with rdata=0.
REQ-033 Back-to-back grants SHALL produce back-to-back responses with no bubble.

Reset
REQ-034 Reset SHALL force FSM=IDLE, rr=1 (so m0 wins the first tie), response valid=0, and all outputs 0 in the cycle after reset.
REQ-035 While reset is high, mN_gnt and mem_en SHALL be 0 regardless of requests.
REQ-036 A response pending at reset SHALL be discarded.

Verification
REQ-037 After reset, m0 and m1 both read, in range -> cycle 0 m0_gnt; cycle 1 m0_rvalid with mem_rdata and m1_gnt; cycle 2 m1_rvalid.
REQ-038 m1 write addr 0x0000_0004, be=4'b0011, wdata 0xAABBCCDD -> mem_en=1, mem_addr=1, mem_we=4'b0011; next cycle m1_rvalid=1, m1_err=0, m1_rdata=0.
REQ-039 m0 read addr 0x0000_C000 (word 0x3000) -> mem_en=0; next cycle m0_rvalid=1, m0_err=1, m0_rdata=0.
REQ-040 m0 with lock=1 for 3 grants while m1 requests continuously -> m1_gnt=0 for those 3 cycles; m0 lock=0 on the 4th grant -> m1 granted on the 5th cycle.
REQ-041 Reset asserted the cycle after a grant -> no rvalid in the following cycle; FSM in IDLE; the first tie afterwards goes to m0.
REQ-042 Continuous simultaneous unlocked requests for 8 cycles -> grants alternate m0,m1,... with exactly 4 each and one response per cycle.
